// File: rtl/jam_pkg.sv
// Shared state encoding, default sizes and a clog2 helper for the exhaustive job-assignment solver.
package jam_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_CMP   = 2'd2,
    S_DONE  = 2'd3
  } jam_state_e;

  localparam int JAM_N_DEF      = 8;
  localparam int JAM_COST_W_DEF = 7;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/jam_next_perm.sv
// Combinational next-lexicographic-permutation generator; last_o flags a strictly descending input.
module jam_next_perm #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N*IDX_W-1:0] perm_i,
  output logic [N*IDX_W-1:0] next_o,
  output logic               last_o
);

  logic [IDX_W-1:0] p [N];
  logic [IDX_W-1:0] s [N];
  logic [IDX_W-1:0] q [N];
  logic [IDX_W-1:0] piv;
  logic [IDX_W-1:0] succ;
  logic             found;

  always_comb begin
    for (int i = 0; i < N; i++) p[i] = perm_i[i*IDX_W +: IDX_W];
    found = 1'b0;
    piv   = '0;
    for (int i = 0; i < N - 1; i++) begin
      if (p[i] < p[i+1]) begin
        found = 1'b1;
        piv   = IDX_W'(i);
      end
    end
    // the element right of the pivot is always larger, so succ starts valid
    succ = piv + 1'b1;
    for (int i = 0; i < N; i++) begin
      if (i > int'(piv) && p[i] > p[piv]) succ = IDX_W'(i);
    end
    s       = p;
    s[piv]  = p[succ];
    s[succ] = p[piv];
    q       = s;
    for (int i = 0; i < N; i++) begin
      if (i > int'(piv)) q[i] = s[IDX_W'(N + int'(piv) - i)];
    end
    next_o = '0;
    for (int i = 0; i < N; i++) next_o[i*IDX_W +: IDX_W] = q[i];
    last_o = ~found;
  end

endmodule

// File: rtl/jam_perm_search.sv
// Exhaustive worker->job assignment search: minimum total cost and tie count over all N! permutations.
// Optional JAM_BEST_PERM_EN adds the BestPerm port (first lexicographic minimum).
module jam_perm_search
  import jam_pkg::*;
#(
  parameter int N      = JAM_N_DEF,
  parameter int IDX_W  = 3,
  parameter int COST_W = JAM_COST_W_DEF,
  parameter int SUM_W  = 10,
  parameter int CNT_W  = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               Start,
  output logic [IDX_W-1:0]   W,
  output logic [IDX_W-1:0]   J,
  input  logic [COST_W-1:0]  Cost,
  output logic               Busy,
  output logic               Valid,
`ifdef JAM_BEST_PERM_EN
  output logic [N*IDX_W-1:0] BestPerm,
`endif
  output logic [SUM_W-1:0]   MinCost,
  output logic [CNT_W-1:0]   MatchCount
);

  localparam int PW = N * IDX_W;

  function automatic logic [PW-1:0] ident();
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*IDX_W +: IDX_W] = IDX_W'(i);
    return r;
  endfunction

  localparam logic [PW-1:0] IDENT = ident();

  if (SUM_W < COST_W + clog2(N)) begin : g_sum_w_check
    $error("jam_perm_search: SUM_W too narrow for N*(2^COST_W-1)");
  end

  jam_state_e       state_q;
  logic [PW-1:0]    perm_q;
  logic [SUM_W-1:0] min_q, sum_q, mincost_q;
  logic [CNT_W-1:0] cnt_q, matchcnt_q;
  logic [IDX_W-1:0] w_q, j_q;
  logic             busy_q, valid_q;

  logic [PW-1:0]    next_perm;
  logic             is_last;
  logic [IDX_W-1:0] k_d, j_d;
  logic [SUM_W-1:0] sum_d;
  logic [CNT_W-1:0] cnt_d;

  jam_next_perm #(.N(N), .IDX_W(IDX_W)) u_next_perm (
    .perm_i (perm_q),
    .next_o (next_perm),
    .last_o (is_last)
  );

  assign k_d   = w_q + 1'b1;
  assign sum_d = sum_q + SUM_W'(Cost);
  assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    j_d = '0;
    for (int i = 0; i < N; i++) begin
      if (k_d == IDX_W'(i)) j_d = perm_q[i*IDX_W +: IDX_W];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      perm_q     <= IDENT;
      min_q      <= '1;
      cnt_q      <= '0;
      sum_q      <= '0;
      w_q        <= '0;
      j_q        <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      mincost_q  <= '0;
      matchcnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          valid_q <= 1'b0;
          // a Start landing in the Valid cycle is dropped
          if (Start && !valid_q) begin
            perm_q  <= IDENT;
            min_q   <= '1;
            cnt_q   <= '0;
            sum_q   <= '0;
            w_q     <= '0;
            j_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          sum_q <= sum_d;
          if (w_q == IDX_W'(N - 1)) begin
            state_q <= S_CMP;
          end else begin
            w_q <= k_d;
            j_q <= j_d;
          end
        end
        S_CMP: begin
          if (sum_q < min_q) begin
            min_q <= sum_q;
            cnt_q <= CNT_W'(1);
          end else if (sum_q == min_q) begin
            cnt_q <= cnt_d;
          end
          sum_q <= '0;
          w_q   <= '0;
          if (is_last) begin
            j_q     <= '0;
            state_q <= S_DONE;
          end else begin
            perm_q  <= next_perm;
            j_q     <= next_perm[IDX_W-1:0];
            state_q <= S_ISSUE;
          end
        end
        S_DONE: begin
          mincost_q  <= min_q;
          matchcnt_q <= cnt_q;
          valid_q    <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef JAM_BEST_PERM_EN
  logic [PW-1:0] best_q, bestperm_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      best_q     <= '0;
      bestperm_q <= '0;
    end else begin
      if (state_q == S_CMP && sum_q < min_q) best_q <= perm_q;
      if (state_q == S_DONE) bestperm_q <= best_q;
    end
  end

  assign BestPerm = bestperm_q;
`endif

  assign W          = w_q;
  assign J          = j_q;
  assign Busy       = busy_q;
  assign Valid      = valid_q;
  assign MinCost    = mincost_q;
  assign MatchCount = matchcnt_q;

endmodule

// File: tb/tb_jam_perm_search.sv
// Bench for jam_perm_search: three instances (N=3, N=3 with 2-bit count, N=4) checked against
// a brute-force enumeration model over random and directed cost tables.
module tb_jam_perm_search;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst_n;
  logic        st   [3];
  logic [1:0]  w    [3];
  logic [1:0]  j    [3];
  logic [6:0]  cost [3];
  logic        busy [3];
  logic        vld  [3];
  logic [9:0]  minc [3];
  logic [15:0] mcnt0, mcnt2;
  logic [1:0]  mcnt1;
`ifdef JAM_BEST_PERM_EN
  logic [5:0]  bp0, bp1;
  logic [7:0]  bp2;
`endif

  int cm [3][4][4];
  int n_cmp = 0;
  int n_bad = 0;

  always_comb begin
    for (int d = 0; d < 3; d++) cost[d] = 7'(cm[d][w[d]][j[d]]);
  end

  jam_perm_search #(.N(3), .IDX_W(2), .COST_W(7), .SUM_W(10), .CNT_W(16)) u0 (
    .CLK(CLK), .RST_N(rst_n), .Start(st[0]), .W(w[0]), .J(j[0]), .Cost(cost[0]),
    .Busy(busy[0]), .Valid(vld[0]),
`ifdef JAM_BEST_PERM_EN
    .BestPerm(bp0),
`endif
    .MinCost(minc[0]), .MatchCount(mcnt0));

  jam_perm_search #(.N(3), .IDX_W(2), .COST_W(7), .SUM_W(10), .CNT_W(2)) u1 (
    .CLK(CLK), .RST_N(rst_n), .Start(st[1]), .W(w[1]), .J(j[1]), .Cost(cost[1]),
    .Busy(busy[1]), .Valid(vld[1]),
`ifdef JAM_BEST_PERM_EN
    .BestPerm(bp1),
`endif
    .MinCost(minc[1]), .MatchCount(mcnt1));

  jam_perm_search #(.N(4), .IDX_W(2), .COST_W(7), .SUM_W(10), .CNT_W(16)) u2 (
    .CLK(CLK), .RST_N(rst_n), .Start(st[2]), .W(w[2]), .J(j[2]), .Cost(cost[2]),
    .Busy(busy[2]), .Valid(vld[2]),
`ifdef JAM_BEST_PERM_EN
    .BestPerm(bp2),
`endif
    .MinCost(minc[2]), .MatchCount(mcnt2));

  function automatic int get_cnt(input int d);
    case (d)
      0:       return int'(mcnt0);
      1:       return int'(mcnt1);
      default: return int'(mcnt2);
    endcase
  endfunction

`ifdef JAM_BEST_PERM_EN
  function automatic int get_bp(input int d);
    case (d)
      0:       return int'(bp0);
      1:       return int'(bp1);
      default: return int'(bp2);
    endcase
  endfunction
`endif

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Enumerate every assignment as an n-digit base-n number (worker 0 most significant),
  // keep the distinct-job ones; counting upward visits permutations in lexicographic order.
  task automatic model(input int d, input int n, input int sat,
                       output int mn, output int ct, output int bp);
    int total, rem, used, ok, s, pk, dig;
    mn = 32'h7fffffff; ct = 0; bp = 0; total = 1;
    for (int k = 0; k < n; k++) total = total * n;
    for (int x = 0; x < total; x++) begin
      rem = x; used = 0; ok = 1; s = 0; pk = 0;
      for (int k = n - 1; k >= 0; k--) begin
        dig = rem % n;
        rem = rem / n;
        if (((used >> dig) & 1) == 1) ok = 0;
        used = used | (1 << dig);
        s  = s + cm[d][k][dig];
        pk = pk | (dig << (2 * k));
      end
      if (ok == 1) begin
        if (s < mn) begin
          mn = s; ct = 1; bp = pk;
        end else if (s == mn) begin
          ct++;
        end
      end
    end
    if (ct > sat) ct = sat;
  endtask

  task automatic launch(input int d);
    @(negedge CLK);
    st[d] = 1'b1;
    @(posedge CLK);
    #1 st[d] = 1'b0;
  endtask

  // Counts edges after the Start edge until Valid is seen; optionally re-pulses Start
  // and checks that the previous result is still held part-way through.
  task automatic wait_valid(input int d, input int repulse, input int hold_min,
                            input int hold_cnt, output int cyc);
    cyc = 0;
    while (cyc < 2000) begin
      if (repulse == 1 && (cyc == 2 || cyc == 49)) st[d] = 1'b1;
      @(posedge CLK);
      cyc++;
      #1 st[d] = 1'b0;
      @(negedge CLK);
      if (cyc == 1) chk("busy_after_start", int'(busy[d]), 1);
      if (cyc == 10 && hold_min >= 0) begin
        chk("held_mincost", int'(minc[d]), hold_min);
        chk("held_matchcount", get_cnt(d), hold_cnt);
      end
      if (vld[d]) break;
    end
  endtask

  task automatic run_check(input string tag, input int d, input int n, input int sat,
                           input int repulse, input int ign, input int exp_cyc,
                           input int hold_min, input int hold_cnt,
                           output int mn, output int ct);
    int bp, cyc;
    model(d, n, sat, mn, ct, bp);
    launch(d);
    wait_valid(d, repulse, hold_min, hold_cnt, cyc);
    chk({tag, "_latency"}, cyc, exp_cyc);
    chk({tag, "_mincost"}, int'(minc[d]), mn);
    chk({tag, "_matchcount"}, get_cnt(d), ct);
    chk({tag, "_busy_in_valid"}, int'(busy[d]), 0);
`ifdef JAM_BEST_PERM_EN
    chk({tag, "_bestperm"}, get_bp(d), bp);
`endif
    if (ign == 1) st[d] = 1'b1;
    @(posedge CLK);
    #1 st[d] = 1'b0;
    @(negedge CLK);
    chk({tag, "_valid_pulse"}, int'(vld[d]), 0);
    chk({tag, "_busy_after"}, int'(busy[d]), 0);
    chk({tag, "_w_idle"}, int'(w[d]), 0);
    chk({tag, "_j_idle"}, int'(j[d]), 0);
    chk({tag, "_result_held"}, int'(minc[d]), mn);
  endtask

  initial begin
    int mn, ct, mn_a, ct_a, nv;
    int t1 [3][3];
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) st[d] = 1'b0;
    for (int d = 0; d < 3; d++)
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 4; b++) cm[d][a][b] = 0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    for (int d = 0; d < 3; d++) begin
      chk("rst_valid", int'(vld[d]), 0);
      chk("rst_busy", int'(busy[d]), 0);
      chk("rst_mincost", int'(minc[d]), 0);
      chk("rst_matchcount", get_cnt(d), 0);
      chk("rst_w", int'(w[d]), 0);
      chk("rst_j", int'(j[d]), 0);
    end
    rst_n = 1'b1;

    // directed 3x3 table: minimum 10 reached twice
    t1 = '{'{5, 9, 1}, '{3, 2, 8}, '{7, 6, 4}};
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++) cm[0][a][b] = t1[a][b];
    run_check("table3", 0, 3, 65535, 0, 0, 25, -1, 0, mn, ct);
    chk("table3_min_is_10", mn, 10);
    chk("table3_cnt_is_2", ct, 2);

    // random tables, narrow ranges alternate with full range to force ties
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < 3; a++)
        for (int b = 0; b < 3; b++)
          cm[0][a][b] = (r % 2 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 127));
      run_check("rand3", 0, 3, 65535, 0, 0, 25, -1, 0, mn, ct);
    end

    // saturation with 2-bit count: six ties clamp to 3
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++) cm[1][a][b] = 4;
    run_check("sat", 1, 3, 3, 0, 0, 25, -1, 0, mn, ct);

    // N=4 diagonal-zero: unique identity minimum
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) cm[2][a][b] = (a == b) ? 0 : 10;
    run_check("diag4", 2, 4, 65535, 0, 0, 121, -1, 0, mn, ct);

    // N=4 random with Start re-pulsed while Busy
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) cm[2][a][b] = int'($urandom_range(0, 15));
    run_check("repulse4", 2, 4, 65535, 1, 0, 121, -1, 0, mn, ct);
    nv = 0;
    repeat (20) begin
      @(negedge CLK);
      if (vld[2]) nv++;
    end
    chk("repulse4_single_valid", nv, 0);

    // back-to-back: Start in the Valid cycle is dropped, old result held during run two
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++) cm[0][a][b] = int'($urandom_range(0, 126));
    run_check("b2b_first", 0, 3, 65535, 0, 1, 25, -1, 0, mn_a, ct_a);
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++) cm[0][a][b] = 127;
    run_check("b2b_second", 0, 3, 65535, 0, 0, 25, mn_a, ct_a, mn, ct);
    chk("b2b_second_min_381", int'(minc[0]), 381);
    chk("b2b_second_cnt_6", get_cnt(0), 6);

    // reset in the middle of an N=4 search
    launch(2);
    repeat (39) @(posedge CLK);
    @(negedge CLK);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy[2]), 0);
    chk("abort_mincost", int'(minc[2]), 0);
    chk("abort_matchcount", get_cnt(2), 0);
    chk("abort_w", int'(w[2]), 0);
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;
    nv = 0;
    repeat (130) begin
      @(negedge CLK);
      if (vld[2] || busy[2]) nv++;
    end
    chk("abort_no_valid", nv, 0);
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) cm[2][a][b] = int'($urandom_range(0, 127));
    run_check("after_abort", 2, 4, 65535, 0, 0, 121, -1, 0, mn, ct);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
